// File: rtl/vote_session_ctrl.sv
// Voting session controller: round-robin grants to booths, one-hot ballot validation,
// a single forwarding slot toward the tally unit, and session open/close sequencing.
module vote_session_ctrl #(
    parameter int N_BOOTH   = 4,
    parameter int MAX_VOTES = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 open_i,
    input  logic                 close_i,
    input  logic [N_BOOTH-1:0]   booth_req,
    input  logic [8*N_BOOTH-1:0] booth_vote,
    output logic [N_BOOTH-1:0]   booth_gnt,
    output logic                 tally_valid,
    output logic [7:0]           tally_data,
    input  logic                 tally_ready,
    output logic                 tally_clr,
    output logic [7:0]           vote_cnt,
    output logic [7:0]           invalid_cnt,
    output logic [1:0]           state_o
);

    localparam int PW = (N_BOOTH > 1) ? $clog2(N_BOOTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        CLOSING = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      vote_cnt_q, vote_cnt_d;
    logic [7:0]      invalid_cnt_q, invalid_cnt_d;
    logic            tally_valid_q, tally_valid_d;
    logic [7:0]      tally_data_q, tally_data_d;
    logic            tally_clr_q, tally_clr_d;

    logic            found;
    logic [PW-1:0]   gnt_idx;
    logic [PW:0]     rr_sum;
    logic [PW-1:0]   rr_idx;
    logic            slot_free;
    logic            xfer;
    logic            grant;
    logic [7:0]      ballot;
    logic            ballot_ok;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic is_one_hot(input logic [7:0] v);
        return ($countones(v) == 1);
    endfunction

    // Round-robin search starting at ptr_q, wrapping at N_BOOTH-1.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        rr_sum  = '0;
        rr_idx  = '0;
        for (int i = 0; i < N_BOOTH; i++) begin
            rr_sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (rr_sum >= (PW+1)'(N_BOOTH)) begin
                rr_sum = rr_sum - (PW+1)'(N_BOOTH);
            end
            rr_idx = rr_sum[PW-1:0];
            if (!found && booth_req[rr_idx]) begin
                found   = 1'b1;
                gnt_idx = rr_idx;
            end
        end
    end

    assign slot_free = !tally_valid_q || tally_ready;
    assign xfer      = tally_valid_q && tally_ready;
    assign grant     = (state_q == OPEN) && slot_free && found
                       && (vote_cnt_q != 8'(MAX_VOTES));
    assign ballot    = booth_vote[{gnt_idx, 3'b000} +: 8];
    assign ballot_ok = is_one_hot(ballot);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        vote_cnt_d    = vote_cnt_q;
        invalid_cnt_d = invalid_cnt_q;
        tally_valid_d = tally_valid_q;
        tally_data_d  = tally_data_q;
        tally_clr_d   = 1'b0;
        booth_gnt     = '0;

        if (xfer) begin
            tally_valid_d = 1'b0;
        end

        // A freshly loaded ballot overrides the clear from a same-edge transfer.
        if (grant) begin
            booth_gnt[gnt_idx] = 1'b1;
            ptr_d = (gnt_idx == PW'(N_BOOTH - 1)) ? '0 : gnt_idx + PW'(1);
            if (ballot_ok) begin
                tally_valid_d = 1'b1;
                tally_data_d  = ballot;
                vote_cnt_d    = vote_cnt_q + 8'd1;
            end else begin
                invalid_cnt_d = sat_inc(invalid_cnt_q);
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (open_i) begin
                    state_d       = OPEN;
                    tally_clr_d   = 1'b1;
                    vote_cnt_d    = '0;
                    invalid_cnt_d = '0;
                    ptr_d         = '0;
                end
            end
            OPEN: begin
                if (close_i || (vote_cnt_d == 8'(MAX_VOTES))) begin
                    state_d = CLOSING;
                end
            end
            CLOSING: begin
                if (!tally_valid_q || xfer) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            vote_cnt_q    <= '0;
            invalid_cnt_q <= '0;
            tally_valid_q <= 1'b0;
            tally_data_q  <= '0;
            tally_clr_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            vote_cnt_q    <= vote_cnt_d;
            invalid_cnt_q <= invalid_cnt_d;
            tally_valid_q <= tally_valid_d;
            tally_data_q  <= tally_data_d;
            tally_clr_q   <= tally_clr_d;
        end
    end

    assign tally_valid = tally_valid_q;
    assign tally_data  = tally_data_q;
    assign tally_clr   = tally_clr_q;
    assign vote_cnt    = vote_cnt_q;
    assign invalid_cnt = invalid_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl: session clear, round-robin, invalid ballots,
// backpressure, auto-close, close-with-grant, async abort and open/close priority.
module tb_vote_session_ctrl;

    logic        clk;
    logic        rst;
    logic        open_i;
    logic        close_i;
    logic [3:0]  booth_req;
    logic [31:0] booth_vote;
    logic [3:0]  booth_gnt;
    logic        tally_valid;
    logic [7:0]  tally_data;
    logic        tally_ready;
    logic        tally_clr;
    logic [7:0]  vote_cnt;
    logic [7:0]  invalid_cnt;
    logic [1:0]  state_o;

    int errors = 0;
    int checks = 0;

    vote_session_ctrl #(.N_BOOTH(4), .MAX_VOTES(9)) dut (
        .clk         (clk),
        .rst         (rst),
        .open_i      (open_i),
        .close_i     (close_i),
        .booth_req   (booth_req),
        .booth_vote  (booth_vote),
        .booth_gnt   (booth_gnt),
        .tally_valid (tally_valid),
        .tally_data  (tally_data),
        .tally_ready (tally_ready),
        .tally_clr   (tally_clr),
        .vote_cnt    (vote_cnt),
        .invalid_cnt (invalid_cnt),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst         = 1'b0;
        open_i      = 1'b0;
        close_i     = 1'b0;
        booth_req   = 4'b0000;
        booth_vote  = 32'h0;
        tally_ready = 1'b0;
        tick();
        tick();

        check("rst_state", 32'(state_o), 32'd0);
        check("rst_gnt", 32'(booth_gnt), 32'd0);
        check("rst_tv", 32'(tally_valid), 32'd0);
        check("rst_td", 32'(tally_data), 32'd0);
        check("rst_clr", 32'(tally_clr), 32'd0);
        check("rst_vc", 32'(vote_cnt), 32'd0);
        check("rst_ic", 32'(invalid_cnt), 32'd0);

        rst = 1'b1;
        tick();
        check("idle_hold", 32'(state_o), 32'd0);

        // open and basic vote from booth 2
        open_i = 1'b1;
        tick();
        open_i = 1'b0;
        check("open_state", 32'(state_o), 32'd1);
        check("clr_pulse", 32'(tally_clr), 32'd1);
        tick();
        check("clr_one_cycle", 32'(tally_clr), 32'd0);

        booth_req   = 4'b0100;
        booth_vote  = 32'h0004_0000;
        tally_ready = 1'b1;
        #1;
        check("basic_gnt", 32'(booth_gnt), 32'b0100);
        tick();
        booth_req = 4'b0000;
        check("basic_tv", 32'(tally_valid), 32'd1);
        check("basic_td", 32'(tally_data), 32'h04);
        check("basic_vc", 32'(vote_cnt), 32'd1);
        tick();
        check("basic_xfer_tv", 32'(tally_valid), 32'd0);

        // booth 3 alone moves the pointer back to booth 0
        booth_req  = 4'b1000;
        booth_vote = 32'h0800_0000;
        #1;
        check("b3_gnt", 32'(booth_gnt), 32'b1000);
        tick();
        check("b3_vc", 32'(vote_cnt), 32'd2);

        // round-robin with every booth requesting
        booth_req  = 4'b1111;
        booth_vote = 32'h0804_0201;
        #1;
        check("rr0_gnt", 32'(booth_gnt), 32'b0001);
        tick();
        check("rr0_td", 32'(tally_data), 32'h01);
        #1;
        check("rr1_gnt", 32'(booth_gnt), 32'b0010);
        tick();
        check("rr1_td", 32'(tally_data), 32'h02);
        #1;
        check("rr2_gnt", 32'(booth_gnt), 32'b0100);
        tick();
        check("rr2_td", 32'(tally_data), 32'h04);
        #1;
        check("rr3_gnt", 32'(booth_gnt), 32'b1000);
        tick();
        check("rr3_td", 32'(tally_data), 32'h08);
        #1;
        check("rr4_gnt", 32'(booth_gnt), 32'b0001);
        tick();
        check("rr4_td", 32'(tally_data), 32'h01);
        check("rr_vc", 32'(vote_cnt), 32'd7);
        check("rr_tv", 32'(tally_valid), 32'd1);

        // backpressure: pending ballot blocks grants until ready
        booth_req   = 4'b0010;
        tally_ready = 1'b0;
        #1;
        check("bp_no_gnt", 32'(booth_gnt), 32'd0);
        tick();
        check("bp_hold_td", 32'(tally_data), 32'h01);
        check("bp_hold_tv", 32'(tally_valid), 32'd1);
        check("bp_hold_vc", 32'(vote_cnt), 32'd7);
        tally_ready = 1'b1;
        #1;
        check("bp_release_gnt", 32'(booth_gnt), 32'b0010);
        tick();
        booth_req = 4'b0000;
        check("bp_new_td", 32'(tally_data), 32'h02);
        check("bp_new_tv", 32'(tally_valid), 32'd1);
        check("bp_vc", 32'(vote_cnt), 32'd8);

        // ninth vote auto-closes the session
        booth_req = 4'b0100;
        #1;
        check("ac_gnt", 32'(booth_gnt), 32'b0100);
        tick();
        check("ac_vc", 32'(vote_cnt), 32'd9);
        check("ac_closing", 32'(state_o), 32'd2);
        check("ac_td", 32'(tally_data), 32'h04);
        tally_ready = 1'b0;
        #1;
        check("ac_closing_no_gnt", 32'(booth_gnt), 32'd0);
        tick();
        check("ac_wait_xfer", 32'(state_o), 32'd2);
        tally_ready = 1'b1;
        tick();
        check("ac_done", 32'(state_o), 32'd3);
        check("ac_done_tv", 32'(tally_valid), 32'd0);
        #1;
        check("ac_done_no_gnt", 32'(booth_gnt), 32'd0);
        check("ac_done_vc", 32'(vote_cnt), 32'd9);

        // reopen from DONE clears the counters
        booth_req = 4'b0000;
        open_i    = 1'b1;
        tick();
        open_i = 1'b0;
        check("reopen_state", 32'(state_o), 32'd1);
        check("reopen_clr", 32'(tally_clr), 32'd1);
        check("reopen_vc", 32'(vote_cnt), 32'd0);

        // invalid ballots: zero bits, then two bits
        booth_req  = 4'b0001;
        booth_vote = 32'h0804_0200;
        #1;
        check("inv0_gnt", 32'(booth_gnt), 32'b0001);
        tick();
        booth_vote = 32'h0804_0203;
        check("inv0_ic", 32'(invalid_cnt), 32'd1);
        tick();
        check("inv1_ic", 32'(invalid_cnt), 32'd2);
        check("inv1_vc", 32'(vote_cnt), 32'd0);
        check("inv1_tv", 32'(tally_valid), 32'd0);
        for (int i = 0; i < 256; i++) begin
            tick();
        end
        check("inv_sat_ic", 32'(invalid_cnt), 32'd255);
        check("inv_sat_vc", 32'(vote_cnt), 32'd0);
        check("inv_sat_state", 32'(state_o), 32'd1);

        // close in a granting cycle still accepts the ballot
        booth_vote  = 32'h0804_0201;
        close_i     = 1'b1;
        tally_ready = 1'b0;
        #1;
        check("cg_gnt", 32'(booth_gnt), 32'b0001);
        tick();
        close_i   = 1'b0;
        booth_req = 4'b0000;
        check("cg_vc", 32'(vote_cnt), 32'd1);
        check("cg_state", 32'(state_o), 32'd2);
        check("cg_tv", 32'(tally_valid), 32'd1);

        // asynchronous abort between edges
        #1;
        rst = 1'b0;
        #1;
        check("abort_state", 32'(state_o), 32'd0);
        check("abort_tv", 32'(tally_valid), 32'd0);
        check("abort_td", 32'(tally_data), 32'd0);
        check("abort_vc", 32'(vote_cnt), 32'd0);
        check("abort_ic", 32'(invalid_cnt), 32'd0);
        check("abort_gnt", 32'(booth_gnt), 32'd0);
        tick();
        rst = 1'b1;

        // open and close together in IDLE: open wins, close acts next cycle
        open_i  = 1'b1;
        close_i = 1'b1;
        tick();
        open_i = 1'b0;
        check("oc_open_wins", 32'(state_o), 32'd1);
        tick();
        close_i = 1'b0;
        check("oc_closing", 32'(state_o), 32'd2);
        tick();
        check("oc_done", 32'(state_o), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vote_session_ctrl.md
VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 Parameter N_BOOTH, default 4: number of voting booths sharing one tally unit.
REQ-002 Parameter MAX_VOTES, default 9: number of valid votes after which the session auto-closes.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
REQ-005 open_i  input  1  session-open request; level-sampled each cycle.
REQ-006 close_i  input  1  session-close request; level-sampled each cycle.
REQ-007 booth_req  input  N_BOOTH  per-booth request; held until granted.
REQ-008 booth_vote  input  8*N_BOOTH  per-booth 8-bit ballot; booth k occupies bits [8k+7:8k].
REQ-009 booth_gnt  output  N_BOOTH  one-cycle grant; at most one bit set per cycle.
REQ-010 tally_valid  output  1  forwarded ballot is valid.
REQ-011 tally_data  output  8  forwarded one-hot ballot.
REQ-012 tally_ready  input  1  tally unit accepts; transfer occurs when tally_valid and tally_ready are both 1 on a clk edge.
REQ-013 tally_clr  output  1  one-cycle pulse that clears the tally unit at session start.
REQ-014 vote_cnt  output  8  count of valid ballots accepted this session.
REQ-015 invalid_cnt  output  8  count of rejected ballots this session; saturates at 255.
REQ-016 state_o  output  2  FSM state: 0 IDLE, 1 OPEN, 2 CLOSING, 3 DONE.

Function
REQ-017 IDLE to OPEN when open_i=1; in the same edge, tally_clr pulses for one cycle and vote_cnt, invalid_cnt and the arbitration pointer clear.
REQ-018 DONE to OPEN when open_i=1, with the same clear actions as REQ-017; open_i is ignored in OPEN and CLOSING.
REQ-019 OPEN to CLOSING when close_i=1, or when the next vote_cnt value equals MAX_VOTES.
REQ-020 CLOSING to DONE on the first edge where tally_valid is 0, or where a transfer completes; no grants are issued in CLOSING or DONE.
REQ-021 Grant occurs in OPEN only, when at least one booth_req is 1 and the output slot is free (tally_valid=0, or tally_ready=1 in the same cycle).
REQ-022 Round-robin arbitration: the search starts at pointer p and wraps from N_BOOTH-1 to 0; the first requester found is granted; p becomes granted index+1 modulo N_BOOTH; p is unchanged when no grant is issued.
REQ-023 booth_gnt is combinational from the current state and inputs; the ballot of the granted booth is sampled on the same edge.
REQ-024 A sampled ballot with exactly one bit set is valid: tally_data is loaded, tally_valid=1 from the next cycle, and vote_cnt increments.
REQ-025 A sampled ballot with zero bits or more than one bit set is rejected: invalid_cnt increments (saturating) and tally_valid is not set; the reject does not count toward MAX_VOTES.
REQ-026 tally_valid and tally_data hold stable until the transfer; tally_valid clears after the transfer unless a new valid ballot loads in the same edge (back-to-back transfers give one ballot per cycle).
REQ-027 close_i in a cycle that also grants: the granted ballot is accepted and counted, then the FSM moves to CLOSING.
REQ-028 open_i and close_i both 1 in IDLE: open wins; close_i is then evaluated from the following cycle.
REQ-029 vote_cnt never exceeds MAX_VOTES; no grant is issued once vote_cnt equals MAX_VOTES.

Reset
REQ-030 While rst=0: state_o=IDLE, booth_gnt=0, tally_valid=0, tally_data=0, tally_clr=0, vote_cnt=0, invalid_cnt=0, pointer=0.
REQ-031 Reset mid-session aborts immediately: any pending ballot is discarded, with no transfer and no count.

Verification
REQ-032 Clear then basic vote: open_i pulse; tally_clr=1 for exactly one cycle; booth 2 requests with ballot 8'h04 and tally_ready=1 -> booth_gnt=4'b0100, next cycle tally_valid=1, tally_data=8'h04, vote_cnt=1.
REQ-033 Round-robin: all 4 booths request continuously with valid ballots, tally_ready=1 -> grants in order 0,1,2,3,0, one per cycle.
REQ-034 Invalid ballots: ballots 8'h00 then 8'h03 -> invalid_cnt=2, vote_cnt=0, tally_valid stays 0; 256 invalid ballots -> invalid_cnt=255.
REQ-035 Backpressure: tally_ready=0 with a pending ballot -> no grants issued, tally_data held; tally_ready=1 -> transfer, then a grant in the same cycle.
REQ-036 Auto-close: 9 valid votes -> state CLOSING, then DONE after the last transfer; further requests get no grant; vote_cnt=9.
REQ-037 Async abort: rst=0 mid-cycle while tally_valid=1 -> all outputs at reset values before the next edge; state_o=0.
